// File: rtl/mod_enc_shift_ctrl.sv
// Byte-serial ShiftRows buffer sequencer: loads N bytes, holds the block for the consumer, counts NR rounds.
// Optional macro ENC_SHIFT_CTRL_STALL_CNT_EN adds the saturating stall_cnt output.
module mod_enc_shift_ctrl #(
   parameter int N  = 16,
   parameter int NR = 14
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start,
   input  logic        abort,
   input  logic        in_valid,
   input  logic [7:0]  in_byte,
   output logic        in_ready,
   output logic        sh_wr_en,
   output logic [7:0]  sh_inp,
   output logic        blk_valid,
   input  logic        blk_ready,
   output logic        last_round,
   output logic [3:0]  round,
   output logic        busy,
   output logic        done,
   output logic [1:0]  state_dbg
`ifdef ENC_SHIFT_CTRL_STALL_CNT_EN
   ,
   output logic [15:0] stall_cnt
`endif
);

   localparam int              CW       = $clog2(N);
   localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
   localparam logic [3:0]      RND_LAST = 4'(NR - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   byte_cnt, byte_cnt_nxt;
   logic [3:0]      round_nxt;
   logic            blk_valid_nxt;
   logic            done_nxt;

   // Handshakes: a byte moves when in_valid && in_ready on a rising edge; a block is
   // consumed when blk_valid && blk_ready on a rising edge. Neither side may retract early.
   assign in_ready   = (state == LOAD);
   assign sh_wr_en   = in_valid && in_ready;
   assign sh_inp     = in_byte;
   assign last_round = (round == RND_LAST);
   assign busy       = (state != IDLE);
   assign state_dbg  = state;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         byte_cnt  <= '0;
         round     <= '0;
         blk_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         state     <= state_nxt;
         byte_cnt  <= byte_cnt_nxt;
         round     <= round_nxt;
         blk_valid <= blk_valid_nxt;
         done      <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      byte_cnt_nxt  = byte_cnt;
      round_nxt     = round;
      blk_valid_nxt = blk_valid;
      done_nxt      = 1'b0;
      if (abort) begin
         // A byte accepted alongside abort is still written, but its count is dropped.
         state_nxt     = IDLE;
         byte_cnt_nxt  = '0;
         round_nxt     = '0;
         blk_valid_nxt = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt    = LOAD;
                  byte_cnt_nxt = '0;
                  round_nxt    = '0;
               end
            end
            LOAD: begin
               if (sh_wr_en) begin
                  if (byte_cnt == CNT_LAST) begin
                     byte_cnt_nxt  = '0;
                     state_nxt     = HOLD;
                     blk_valid_nxt = 1'b1;
                  end else begin
                     byte_cnt_nxt = byte_cnt + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (blk_ready) begin
                  blk_valid_nxt = 1'b0;
                  if (round == RND_LAST) begin
                     round_nxt = '0;
                     done_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     round_nxt = round + 4'd1;
                     state_nxt = LOAD;
                  end
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

`ifdef ENC_SHIFT_CTRL_STALL_CNT_EN
   logic stall_evt;
   assign stall_evt = ((state == LOAD) && !in_valid) || ((state == HOLD) && !blk_ready);

   // Cleared only by a start that actually launches a block; abort leaves it intact.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= '0;
      end else if ((state == IDLE) && start && !abort) begin
         stall_cnt <= '0;
      end else if (stall_evt && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
